hub75_swap_ctrl: RTL and testbench
==================================

HUB75_SWAP_CTRL -- requirements
Module: hub75_swap_ctrl

Interface
REQ-001 Parameter BASEADDR, default 32'h81010000: byte base of this block's 4-word register window.
REQ-002 Port clk  input  1: the only clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1: reset is asynchronous and active-low.
REQ-004 Port addr  input  32: bus byte address.
REQ-005 Port wdata  input  32: bus write data.
REQ-006 Port wmask  input  4: bus byte-lane write enables.
REQ-007 Port wen  input  1: bus write strobe.
REQ-008 Port ren  input  1: bus read strobe.
REQ-009 Port rdata  output  32: registered read data.
REQ-010 Port ready  output  1: one-cycle bus completion pulse.
REQ-011 Port active  output  1: combinational; high iff BASEADDR <= addr <= BASEADDR+15.
REQ-012 Port frame_end  input  1: one-cycle pulse from the scanner after the last column of the last row at the final PWM step.
REQ-013 Port buffer_select  output  1: front buffer index given to the scanner.
REQ-014 Port scan_enable  output  1: scanner run enable.
REQ-015 Port brightness  output  8: global OE duty value for the scanner.
REQ-016 Port irq  output  1: level interrupt, equal to IRQ_FLAG AND IRQ_EN.

Function
REQ-017 Register map, word offset (addr-BASEADDR)>>2: 0 CTRL, 1 STATUS, 2 FRAME_COUNT, 3 BRIGHTNESS.
REQ-018 CTRL: bit0 SWAP_REQ (write-1 strobe, reads 0), bit1 ENABLE (R/W), bit2 IRQ_EN (R/W); other bits read 0; byte lane 0 only.
REQ-019 STATUS (read): bit0 buffer_select, bit1 swap pending, bit2 IRQ_FLAG; writing 1 to bit2 with wmask[0] clears IRQ_FLAG; other bits read-only.
REQ-020 FRAME_COUNT: 32-bit read-only; increments by 1 on each frame_end while ENABLE=1; wraps 32'hFFFFFFFF -> 0.
REQ-021 BRIGHTNESS: bits[7:0] R/W via wmask[0], drive brightness; upper bits read 0.
REQ-022 Bus: when active and (wen or ren), rdata loads the addressed register and ready is 1 on the next cycle; ready is 0 otherwise; when both wen and ren are high, the write takes effect and rdata returns the pre-write value.
REQ-023 Writes with active=0 are ignored; ready stays 0.
REQ-024 Swap FSM states: IDLE, PENDING.
REQ-025 IDLE -> PENDING on a CTRL write with wmask[0]=1 and wdata[0]=1.
REQ-026 PENDING, ENABLE=1, frame_end=1: toggle buffer_select, set IRQ_FLAG, return to IDLE, all in the same edge.
REQ-027 PENDING, ENABLE=0: the swap executes on the next clock edge, without waiting for frame_end, with the same effects.
REQ-028 SWAP_REQ written while PENDING is ignored: one toggle per pending period.
REQ-029 SWAP_REQ write in IDLE coinciding with frame_end: go to PENDING; the toggle waits for the following frame_end.
REQ-030 IRQ_FLAG set coinciding with a W1C clear: set wins.
REQ-031 buffer_select changes only as defined in REQ-026/027; it never changes mid-frame while ENABLE=1.
REQ-032 scan_enable equals CTRL.ENABLE registered; clearing ENABLE while PENDING leaves state PENDING, then REQ-027 applies.

Reset
REQ-033 On rst_n low, immediately: state IDLE, buffer_select=0, scan_enable=0, IRQ_EN=0, IRQ_FLAG=0, irq=0, FRAME_COUNT=0, brightness=8'hFF, rdata=0, ready=0.
REQ-034 Reset asserted while PENDING discards the pending swap; buffer_select returns to 0.

Verification
REQ-035 Reset, then read offsets 0..3 -> 0, 0, 0, 32'h000000FF; ready=1 exactly one cycle after each ren.
REQ-036 ENABLE=1, write SWAP_REQ, wait 3 cycles, then pulse frame_end -> STATUS=3'b010 before the pulse; after the pulse buffer_select=1 and STATUS=3'b101.
REQ-037 IRQ_EN=1, complete a swap -> irq=1; write STATUS 32'h4 -> irq=0; repeat with the clear coinciding with a swap -> irq stays 1.
REQ-038 ENABLE=0, write SWAP_REQ -> buffer_select toggles 2 cycles after the write cycle; frame_end pulses leave FRAME_COUNT=0.
REQ-039 ENABLE=1, SWAP_REQ write in the same cycle as frame_end, then two more SWAP_REQ writes, then 2 frame_end pulses -> exactly one toggle at the 2nd frame_end; FRAME_COUNT=3.
REQ-040 Preload FRAME_COUNT near wrap by driving 2^32-1 frame_end pulses (or a force), then one more pulse -> reads 0; assert rst_n while PENDING -> buffer_select=0, STATUS=0.

Source files
------------

// File: rtl/hub75_swap_ctrl.sv
// HUB75 double-buffer swap controller: a 4-word register window that requests a
// front/back buffer swap, applies it at a frame boundary and raises an interrupt.
module hub75_swap_ctrl #(
  parameter logic [31:0] BASEADDR = 32'h81010000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  input  logic        frame_end,
  output logic        buffer_select,
  output logic        scan_enable,
  output logic [7:0]  brightness,
  output logic        irq
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_FCOUNT = 2'd2;
  localparam logic [1:0] OFF_BRIGHT = 2'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_do_swap;
  logic        r_enable;
  logic        r_irq_en;
  logic        r_irq_flag;
  logic        r_buf_sel;
  logic [31:0] r_frame_count;
  logic [7:0]  r_bright;
  logic [31:0] r_rdata;
  logic        r_ready;

  logic [3:0]  w_rel;
  logic [1:0]  w_off;
  logic        w_acc;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_swap_req;
  logic        w_stat_clr;
  logic        w_bright_wr;
  logic [31:0] w_rd;
  logic        w_unused;

  // The upper bound is compared in 33 bits so a window at the top of the map cannot wrap.
  assign active = (addr >= BASEADDR) &&
                  ({1'b0, addr} <= ({1'b0, BASEADDR} + 33'd15));

  assign w_rel       = addr[3:0] - BASEADDR[3:0];
  assign w_off       = w_rel[3:2];
  assign w_acc       = active && (wen || ren);
  assign w_wr        = active && wen;
  assign w_ctrl_wr   = w_wr && (w_off == OFF_CTRL) && wmask[0];
  assign w_swap_req  = w_ctrl_wr && wdata[0];
  assign w_stat_clr  = w_wr && (w_off == OFF_STATUS) && wmask[0] && wdata[2];
  assign w_bright_wr = w_wr && (w_off == OFF_BRIGHT) && wmask[0];
  assign w_unused    = ^{wdata[31:8], wmask[3:1], w_rel[1:0]};

  // Swap FSM: a swap waits for frame_end while scanning, or fires at once when stopped.
  always_comb begin
    w_state_nxt = r_state;
    w_do_swap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_swap_req) w_state_nxt = S_PENDING;
      end
      S_PENDING: begin
        if (!r_enable || frame_end) begin
          w_do_swap   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd = 32'd0;
    case (w_off)
      OFF_CTRL:   w_rd = {29'd0, r_irq_en, r_enable, 1'b0};
      OFF_STATUS: w_rd = {29'd0, r_irq_flag, (r_state == S_PENDING), r_buf_sel};
      OFF_FCOUNT: w_rd = r_frame_count;
      OFF_BRIGHT: w_rd = {24'd0, r_bright};
      default:    w_rd = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable      <= 1'b0;
      r_irq_en      <= 1'b0;
      r_irq_flag    <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_frame_count <= 32'd0;
      r_bright      <= 8'hFF;
      r_rdata       <= 32'd0;
      r_ready       <= 1'b0;
    end else begin
      r_ready <= w_acc;
      if (w_acc) r_rdata <= w_rd;
      if (w_ctrl_wr) begin
        r_enable <= wdata[1];
        r_irq_en <= wdata[2];
      end
      if (w_bright_wr) r_bright <= wdata[7:0];
      if (r_enable && frame_end) r_frame_count <= r_frame_count + 32'd1;
      if (w_do_swap) r_buf_sel <= ~r_buf_sel;
      // A swap in the same cycle as a W1C clear keeps the flag set.
      if (w_do_swap)       r_irq_flag <= 1'b1;
      else if (w_stat_clr) r_irq_flag <= 1'b0;
    end
  end

  assign rdata         = r_rdata;
  assign ready         = r_ready;
  assign buffer_select = r_buf_sel;
  assign scan_enable   = r_enable;
  assign brightness    = r_bright;
  assign irq           = r_irq_flag && r_irq_en;

endmodule

// File: tb/tb_hub75_swap_ctrl.sv
// Directed bench for hub75_swap_ctrl: bus reads/writes are scoreboarded through an
// expected-data queue popped on ready; scanner-side outputs are checked directly.
module tb_hub75_swap_ctrl;

  localparam logic [31:0] BASE = 32'h81010000;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ready;
  logic        active;
  logic        frame_end;
  logic        buffer_select;
  logic        scan_enable;
  logic [7:0]  brightness;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  hub75_swap_ctrl #(.BASEADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .wdata        (wdata),
    .wmask        (wmask),
    .wen          (wen),
    .ren          (ren),
    .rdata        (rdata),
    .ready        (ready),
    .active       (active),
    .frame_end    (frame_end),
    .buffer_select(buffer_select),
    .scan_enable  (scan_enable),
    .brightness   (brightness),
    .irq          (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Bus transfer issued at a negedge; every in-window access expects ready + rdata next cycle.
  task automatic bus(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp);
    addr  = a;
    wdata = d;
    wmask = m;
    wen   = we;
    ren   = re;
    @(posedge clk);
    if (a >= BASE && a <= BASE + 32'd15) exp_q.push_back(exp);
    @(negedge clk);
    wen   = 1'b0;
    ren   = 1'b0;
    wmask = 4'h0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [31:0] exp_pre);
    bus(1'b1, 1'b0, BASE + {28'd0, off, 2'b00}, d, 4'h1, exp_pre);
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp);
    bus(1'b0, 1'b1, BASE + {28'd0, off, 2'b00}, 32'd0, 4'h0, exp);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0; frame_end = 1'b0;
    addr = BASE; wdata = 32'd0; wmask = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_bsel", {31'd0, buffer_select}, 32'd0);
    check("rst_scan", {31'd0, scan_enable}, 32'd0);
    check("rst_bright", {24'd0, brightness}, 32'h000000FF);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", {31'd0, ready}, 32'd0);
      end else begin
        check("bus_rdata", rdata, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      check("ready_missing", {31'd0, ready}, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    do_reset();

    // Reset values of all four registers
    rd(2'd0, 32'd0);
    rd(2'd1, 32'd0);
    rd(2'd2, 32'd0);
    rd(2'd3, 32'h000000FF);

    // Address decode boundaries and out-of-window writes
    addr = BASE - 32'd1; #1 check("active_below", {31'd0, active}, 32'd0);
    addr = BASE + 32'd15; #1 check("active_top", {31'd0, active}, 32'd1);
    addr = BASE + 32'd16; #1 check("active_above", {31'd0, active}, 32'd0);
    @(negedge clk);
    bus(1'b1, 1'b0, BASE + 32'd16, 32'h3, 4'hF, 32'd0);
    bus(1'b1, 1'b0, BASE - 32'd4, 32'h11, 4'hF, 32'd0);
    check("inactive_scan", {31'd0, scan_enable}, 32'd0);
    check("inactive_bright", {24'd0, brightness}, 32'h000000FF);

    // Swap at frame_end while scanning
    wr(2'd0, 32'h2, 32'h0);
    check("scan_on", {31'd0, scan_enable}, 32'd1);
    wr(2'd0, 32'h3, 32'h2);
    repeat (3) @(negedge clk);
    rd(2'd1, 32'h2);
    check("bsel_wait", {31'd0, buffer_select}, 32'd0);
    pulse_fe();
    check("bsel_swap1", {31'd0, buffer_select}, 32'd1);
    rd(2'd1, 32'h5);

    // Interrupt set/clear and set-wins-over-clear
    wr(2'd1, 32'h4, 32'h5);
    rd(2'd1, 32'h1);
    wr(2'd0, 32'h6, 32'h2);
    check("irq_en_noflag", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h7, 32'h6);
    rd(2'd1, 32'h3);
    pulse_fe();
    check("irq_set", {31'd0, irq}, 32'd1);
    check("bsel_swap2", {31'd0, buffer_select}, 32'd0);
    wr(2'd1, 32'h4, 32'h4);
    check("irq_clr", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h7, 32'h6);
    frame_end = 1'b1;
    wr(2'd1, 32'h4, 32'h2);
    frame_end = 1'b0;
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    check("bsel_swap3", {31'd0, buffer_select}, 32'd1);
    rd(2'd2, 32'd3);

    // Brightness byte lane
    bus(1'b1, 1'b0, BASE + 32'hC, 32'hFFFFFF5A, 4'h1, 32'h000000FF);
    check("bright_wr", {24'd0, brightness}, 32'h0000005A);
    bus(1'b1, 1'b0, BASE + 32'hC, 32'h00000011, 4'hE, 32'h0000005A);
    rd(2'd3, 32'h0000005A);

    // Stopped scanner: swap applies two cycles after the write, frame_end ignored
    do_reset();
    wr(2'd0, 32'h1, 32'h0);
    check("stop_bsel_early", {31'd0, buffer_select}, 32'd0);
    @(negedge clk);
    check("stop_bsel_swap", {31'd0, buffer_select}, 32'd1);
    pulse_fe();
    pulse_fe();
    rd(2'd2, 32'd0);
    rd(2'd1, 32'h5);

    // Request coinciding with frame_end, repeated requests ignored
    do_reset();
    wr(2'd0, 32'h2, 32'h0);
    frame_end = 1'b1;
    wr(2'd0, 32'h3, 32'h2);
    frame_end = 1'b0;
    check("coinc_no_swap", {31'd0, buffer_select}, 32'd0);
    rd(2'd1, 32'h2);
    wr(2'd0, 32'h3, 32'h2);
    wr(2'd0, 32'h3, 32'h2);
    pulse_fe();
    check("coinc_swap", {31'd0, buffer_select}, 32'd1);
    pulse_fe();
    check("coinc_one_toggle", {31'd0, buffer_select}, 32'd1);
    rd(2'd2, 32'd3);
    rd(2'd1, 32'h5);

    // Frame counter wrap
    force dut.r_frame_count = 32'hFFFFFFFE;
    #1 release dut.r_frame_count;
    @(negedge clk);
    pulse_fe();
    rd(2'd2, 32'hFFFFFFFF);
    pulse_fe();
    rd(2'd2, 32'h0);

    // Asynchronous reset while a swap is pending
    wr(2'd0, 32'h3, 32'h2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_bsel", {31'd0, buffer_select}, 32'd0);
    check("async_scan", {31'd0, scan_enable}, 32'd0);
    check("async_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, 32'h0);
    rd(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    check("bsel_after_rst", {31'd0, buffer_select}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
